// File: rtl/sample_queue_pkg.sv
// sample_queue_pkg: shared defaults, FSM state type and the wrap-around pointer increment
package sample_queue_pkg;
  localparam int DEPTH_DEF = 1536;
  localparam int TAPS_DEF = 1021;
  localparam int PW_DEF = $clog2(DEPTH_DEF);
  typedef enum logic {IDLE, READ} state_e;
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 32'd0 : p + 32'd1;
  endfunction
endpackage

// File: rtl/sample_ram.sv
// sample_ram: DEPTH x W simple dual-port RAM, one write port and a registered read port
module sample_ram #(
  parameter int DEPTH = 1536,
  parameter int W = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/sample_queue.sv
// sample_queue: circular sample store that bursts the newest TAPS samples, oldest first, on each new sample
module sample_queue
  import sample_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_smpl,
  input  logic [15:0] new_smpl,
  output logic [15:0] smpl_out,
  output logic        smpl_vld,
  output logic        sequencing,
  output logic        ovr
);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return PW'(wrap_inc(32'(p), DEPTH));
  endfunction
  state_e state_q, state_d;
  logic [PW-1:0] new_ptr_q, new_ptr_d, old_ptr_q, old_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d, rd_cnt_q, rd_cnt_d;
  logic ovr_q, ovr_d, vld_q, vld_d, we;
  logic [15:0] rdata;
  always_comb begin
    state_d = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    rd_cnt_d = rd_cnt_q;
    we = 1'b0;
    ovr_d = ovr_q | (wrt_smpl & (state_q == READ));
    vld_d = state_q == READ;
    if (state_q == IDLE) begin
      if (wrt_smpl) begin
        we = 1'b1;
        new_ptr_d = inc(new_ptr_q);
        old_ptr_d = (fill_cnt_q == TAPS_C) ? inc(old_ptr_q) : old_ptr_q;
        fill_cnt_d = (fill_cnt_q == TAPS_C) ? fill_cnt_q : fill_cnt_q + 1'b1;
        if (fill_cnt_d == TAPS_C) begin
          state_d = READ;
          rd_ptr_d = old_ptr_d;
          rd_cnt_d = '0;
        end
      end
    end else begin
      rd_ptr_d = inc(rd_ptr_q);
      rd_cnt_d = rd_cnt_q + 1'b1;
      state_d = (rd_cnt_q == TAPS_C - 1'b1) ? IDLE : READ;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_cnt_q <= '0;
      rd_cnt_q <= '0;
      ovr_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ovr_q <= ovr_d;
      vld_q <= vld_d;
    end
  end
  sample_ram #(.DEPTH(DEPTH), .W(16), .AW(PW)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(new_ptr_q),
    .wdata(new_smpl),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  assign smpl_vld = vld_q;
  assign smpl_out = vld_q ? rdata : 16'h0;
  assign sequencing = state_q == READ;
  assign ovr = ovr_q;
endmodule
